// File: rtl/scan_harness_driver.sv
// Host-side driver for the 3-wire scan harness (di, stb, do).
// Shifts a stimulus vector out MSB-first, strobes it in, then shifts the captured response back.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | ready for start; di held low
// SHIFT   | driving latched vector onto di, MSB first
// STROBE  | stb high for one cycle; harness loads din and captures dout
// CAPTURE | sampling dut_do into the response word, MSB first
module scan_harness_driver #(
   parameter int DIN_N  = 256,
   parameter int DOUT_N = 256
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [DIN_N-1:0]  vec_in,
   output logic              ready,
   output logic              busy,
   output logic              di,
   output logic              stb,
   input  logic              dut_do,
   output logic [DOUT_N-1:0] resp_out,
   output logic              resp_valid
);

   localparam int MAX_N = (DIN_N > DOUT_N) ? DIN_N : DOUT_N;
   localparam int CNT_W = $clog2(MAX_N + 1);
   localparam logic [CNT_W-1:0] DIN_TC  = CNT_W'(DIN_N);
   localparam logic [CNT_W-1:0] DOUT_TC = CNT_W'(DOUT_N - 1);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      SHIFT   = 2'd1,
      STROBE  = 2'd2,
      CAPTURE = 2'd3
   } state_t;

   state_t              state;
   logic [DIN_N-1:0]    vec_sh;
   logic [DOUT_N-1:0]   resp_sh;
   logic [CNT_W-1:0]    cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         ready      <= 1'b1;
         busy       <= 1'b0;
         di         <= 1'b0;
         stb        <= 1'b0;
         resp_valid <= 1'b0;
         resp_out   <= '0;
         cnt        <= '0;
         vec_sh     <= '0;
         resp_sh    <= '0;
      end else begin
         resp_valid <= 1'b0;
         case (state)
            IDLE: begin
               di <= 1'b0;
               if (start) begin
                  // MSB goes out on the accept edge; the rest waits in vec_sh.
                  di     <= vec_in[DIN_N-1];
                  vec_sh <= vec_in << 1;
                  cnt    <= CNT_W'(1);
                  ready  <= 1'b0;
                  busy   <= 1'b1;
                  state  <= SHIFT;
               end
            end
            SHIFT: begin
               if (cnt == DIN_TC) begin
                  di    <= 1'b0;
                  stb   <= 1'b1;
                  state <= STROBE;
               end else begin
                  di     <= vec_sh[DIN_N-1];
                  vec_sh <= vec_sh << 1;
                  cnt    <= cnt + CNT_W'(1);
               end
            end
            STROBE: begin
               stb   <= 1'b0;
               cnt   <= '0;
               state <= CAPTURE;
            end
            CAPTURE: begin
               resp_sh <= (resp_sh << 1) | DOUT_N'(dut_do);
               if (cnt == DOUT_TC) begin
                  resp_out   <= (resp_sh << 1) | DOUT_N'(dut_do);
                  resp_valid <= 1'b1;
                  ready      <= 1'b1;
                  busy       <= 1'b0;
                  state      <= IDLE;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_scan_harness_driver.sv
// Bench for scan_harness_driver: an 8-bit identity-ROI harness and a 256-bit inverting-ROI harness,
// with a queue scoreboard fed at accept time and drained when resp_valid appears.
module tb_scan_harness_driver;

   localparam int N0 = 8;
   localparam int N1 = 256;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         rst;
   logic         start_s [2];
   logic [255:0] vec_s   [2];
   logic         ready_s [2];
   logic         busy_s  [2];
   logic         di_s    [2];
   logic         stb_s   [2];
   logic         rv_s    [2];
   logic         do_s    [2];
   logic [N0-1:0] resp0;
   logic [N1-1:0] resp1;
   logic [255:0]  resp_s [2];

   assign resp_s[0] = 256'(resp0);
   assign resp_s[1] = resp1;

   scan_harness_driver #(.DIN_N(N0), .DOUT_N(N0)) dut0 (
      .clk(clk), .rst(rst), .start(start_s[0]), .vec_in(vec_s[0][N0-1:0]),
      .ready(ready_s[0]), .busy(busy_s[0]), .di(di_s[0]), .stb(stb_s[0]),
      .dut_do(do_s[0]), .resp_out(resp0), .resp_valid(rv_s[0])
   );

   scan_harness_driver #(.DIN_N(N1), .DOUT_N(N1)) dut1 (
      .clk(clk), .rst(rst), .start(start_s[1]), .vec_in(vec_s[1]),
      .ready(ready_s[1]), .busy(busy_s[1]), .di(di_s[1]), .stb(stb_s[1]),
      .dut_do(do_s[1]), .resp_out(resp1), .resp_valid(rv_s[1])
   );

   function automatic int nn(input int i);
      return (i == 0) ? N0 : N1;
   endfunction

   function automatic logic [255:0] msk(input int i);
      return (i == 0) ? 256'hFF : '1;
   endfunction

   // Instance 0 has an identity ROI, instance 1 an inverting ROI.
   function automatic logic [255:0] roi(input int i, input logic [255:0] x);
      return (i == 0) ? (x & msk(i)) : (~x & msk(i));
   endfunction

   // Harness shift-register model (environment, not the reference).
   logic [255:0] h_shr [2];
   logic [255:0] h_din [2];
   logic [255:0] h_dout[2];

   always @(posedge clk) begin
      for (int i = 0; i < 2; i++) begin
         h_shr[i] <= ((h_shr[i] << 1) | 256'(di_s[i])) & msk(i);
         if (stb_s[i]) begin
            h_din[i]  <= h_shr[i];
            h_dout[i] <= roi(i, h_din[i]);
         end else begin
            h_dout[i] <= (h_dout[i] << 1) & msk(i);
         end
      end
   end

   assign do_s[0] = h_dout[0][N0-1];
   assign do_s[1] = h_dout[1][N1-1];

   // Reference model: transaction-level view of what the harness holds.
   int           cyc = 0;
   bit           active  [2];
   bit           done_now[2];
   int           acc     [2];
   logic [255:0] avec    [2];
   logic [255:0] loaded  [2];
   logic [255:0] prev    [2];
   logic [255:0] hold    [2];
   logic [255:0] q0[$];
   logic [255:0] q1[$];
   int checks = 0;
   int failures = 0;

   initial begin
      for (int i = 0; i < 2; i++) begin
         active[i] = 1'b0; done_now[i] = 1'b0; acc[i] = 0;
         avec[i] = '0; loaded[i] = '0; prev[i] = '0; hold[i] = '0;
         h_shr[i] = '0; h_din[i] = '0; h_dout[i] = '0;
      end
   end

   always @(posedge clk) begin
      cyc = cyc + 1;
      for (int i = 0; i < 2; i++) begin
         done_now[i] = 1'b0;
         if (rst) begin
            hold[i] = '0;
            if (active[i]) begin
               active[i] = 1'b0;
               if (i == 0) q0.delete(q0.size() - 1);
               else        q1.delete(q1.size() - 1);
               // Harness din only changes if the strobe edge was already reached.
               if (cyc < acc[i] + nn(i) + 1) loaded[i] = prev[i];
            end
         end else if (active[i]) begin
            if (cyc == acc[i] + 2 * nn(i) + 1) begin
               active[i]   = 1'b0;
               done_now[i] = 1'b1;
            end
         end else if (start_s[i]) begin
            if (i == 0) q0.push_back(roi(i, loaded[i]));
            else        q1.push_back(roi(i, loaded[i]));
            prev[i]   = loaded[i];
            loaded[i] = vec_s[i] & msk(i);
            avec[i]   = vec_s[i] & msk(i);
            acc[i]    = cyc;
            active[i] = 1'b1;
         end
      end
   end

   task automatic chk(input string nm, input int i, input logic [255:0] act, input logic [255:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s inst%0d got=%h want=%h t=%0t", nm, i, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (cyc >= 1) begin
         for (int i = 0; i < 2; i++) begin : mon
            int d;
            logic edi;
            logic [255:0] e;
            d = cyc - acc[i];
            edi = (active[i] && d >= 0 && d < nn(i)) ? avec[i][nn(i) - 1 - d] : 1'b0;
            chk("ready", i, 256'(ready_s[i]), 256'(!active[i]));
            chk("busy", i, 256'(busy_s[i]), 256'(active[i]));
            chk("di", i, 256'(di_s[i]), 256'(edi));
            chk("stb", i, 256'(stb_s[i]), 256'(active[i] && d == nn(i)));
            chk("resp_valid", i, 256'(rv_s[i]), 256'(done_now[i]));
            if (rv_s[i] === 1'b1) begin
               if ((i == 0 && q0.size() == 0) || (i == 1 && q1.size() == 0)) begin
                  checks++;
                  failures++;
                  $display("FAIL unexpected_resp inst%0d got=%h want=none", i, resp_s[i]);
               end else begin
                  e = (i == 0) ? q0.pop_front() : q1.pop_front();
                  chk("resp_out", i, resp_s[i], e);
                  if (i == 1) begin
                     chk("bit255", i, 256'(resp_s[i][255]), 256'(e[255]));
                     chk("bit128", i, 256'(resp_s[i][128]), 256'(e[128]));
                     chk("bit0", i, 256'(resp_s[i][0]), 256'(e[0]));
                  end
                  hold[i] = e;
               end
            end else begin
               chk("resp_hold", i, resp_s[i], hold[i]);
            end
         end
      end
   end

   task automatic issue(input int i, input logic [255:0] v);
      start_s[i] = 1'b1;
      vec_s[i]   = v;
      @(negedge clk);
      start_s[i] = 1'b0;
      vec_s[i]   = {8{$urandom}};
   endtask

   task automatic wait_done(input int i, input bit noise);
      int n;
      int d;
      n = 0;
      while (!done_now[i] && n < 3000) begin
         @(negedge clk);
         n++;
         if (!done_now[i] && noise) begin
            d = cyc - acc[i];
            start_s[i] = (active[i] && d < 2 * nn(i) - 2) ? 1'($urandom_range(0, 1)) : 1'b0;
            vec_s[i]   = {8{$urandom}};
         end
      end
      start_s[i] = 1'b0;
      if (!done_now[i]) begin
         checks++;
         failures++;
         $display("FAIL wait_done inst%0d got=timeout want=resp_valid", i);
      end
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog got=timeout want=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      for (int i = 0; i < 2; i++) begin
         start_s[i] = 1'b0;
         vec_s[i]   = '0;
      end
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      issue(0, 256'hA5); wait_done(0, 1'b0);
      issue(0, 256'h3C); wait_done(0, 1'b0);
      issue(0, 256'hFF); wait_done(0, 1'b0);
      issue(0, 256'h3C); wait_done(0, 1'b1);

      // Abort 5A during SHIFT; the following 01 must see the prior 3C load.
      issue(0, 256'h5A);
      repeat (4) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      issue(0, 256'h01); wait_done(0, 1'b0);

      repeat (20) begin
         repeat ($urandom_range(0, 2)) @(negedge clk);
         issue(0, 256'($urandom_range(0, 255)));
         if ($urandom_range(0, 5) == 0) begin
            repeat ($urandom_range(1, 15)) @(negedge clk);
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
         end else begin
            wait_done(0, 1'b1);
         end
      end

      issue(1, '0);            wait_done(1, 1'b0);
      issue(1, {64{4'hA}});    wait_done(1, 1'b0);
      issue(1, {8{$urandom}}); wait_done(1, 1'b1);
      issue(1, '0);            wait_done(1, 1'b0);
      repeat (3) @(negedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/scan_harness_driver.md
Name: scan_harness_driver

Overview:
- Host-side driver for the 3-wire scan interface (di, stb, do) of the fuzzer/minitest top-level harness.
- Serializes a parallel stimulus vector onto di, then pulses stb to load it into the ROI input register.
- Deserializes the ROI response captured by that same strobe from the do stream.
- Used in simulation benches and on-board harnesses to exercise ROI designs without parallel I/O.

Parameters:
- DIN_N, 256, width of the harness input shift register / stimulus vector.
- DOUT_N, 256, width of the harness output shift register / response vector.

Ports:
- clk  input  1  single clock, shared with the harness top.
- rst  input  1  synchronous active-high reset.
- start  input  1  request a transaction; accepted only when ready=1.
- vec_in  input  DIN_N  stimulus vector; sampled on the accept edge.
- ready  output  1  high in IDLE.
- busy  output  1  equals ~ready.
- di  output  DIN_N-serial  1  serial data to harness di; registered.
- stb  output  1  load strobe to harness stb; registered, one-cycle pulse.
- dut_do  input  1  serial response from harness do.
- resp_out  output  DOUT_N  last deserialized response; held between transactions.
- resp_valid  output  1  one-cycle pulse when resp_out is updated.

Behaviour:
- Reset values: state=IDLE, ready=1, busy=0, di=0, stb=0, resp_valid=0, resp_out=0, counter=0.
- Harness model (decided contract):
  - din_shr shifts left on every edge, taking di into bit 0.
  - On an stb edge: din<=din_shr and dout_shr<=dout.
  - Otherwise dout_shr shifts left.
  - do = dout_shr[MSB].
- States: IDLE -> SHIFT -> STROBE -> CAPTURE -> IDLE.
- Edge numbering: E0 is the accept edge (IDLE, start=1). Edges Ek follow it.
- IDLE:
  - On start at E0: latch vec_in, di<=vec[DIN_N-1], cnt<=1, go to SHIFT.
  - With start=0: di=0, no change.
- SHIFT:
  - At edge Ek (1<=k<DIN_N): di<=vec[DIN_N-1-k].
  - The harness samples vec MSB-first at E1..E_DIN_N.
  - At E_DIN_N: di<=0, stb<=1, go to STROBE.
- STROBE:
  - At E_DIN_N+1 the harness loads din and captures dout. Driver sets stb<=0, cnt<=0, go to CAPTURE.
  - stb is high for exactly one cycle per transaction.
- CAPTURE:
  - At edge E_DIN_N+1+j (j=1..DOUT_N), sample dut_do into response bit DOUT_N-j (MSB first).
  - At the final edge: resp_out<=full word, resp_valid<=1, go to IDLE.
- Latency: resp_valid is high in the cycle after edge E_(DIN_N+DOUT_N+1), i.e. DIN_N+DOUT_N+2 cycles after the accept cycle.
- Response semantics:
  - The stb edge captures dout computed from the previously loaded din.
  - resp_out of transaction n is therefore the ROI response to vector n-1.
  - The first response after power-up reflects the harness's uninitialized din; software discards it.
- start during SHIFT/STROBE/CAPTURE is ignored; vec_in is not re-sampled.
- start may be asserted in the same cycle resp_valid=1 (state is IDLE). It is accepted, giving back-to-back transactions with no dead cycle.
- di is 0 in all cycles outside SHIFT.
- rst mid-transaction:
  - Next cycle state=IDLE, di=0, stb=0, resp_valid=0.
  - resp_out is cleared to 0.
  - A pending stb is never emitted. Partial shifts leave harness din unchanged, because no stb is issued.
- Counter width is clog2(max(DIN_N,DOUT_N)+1). No wrap occurs within a state.

Test Plan:
- Apply rst for 2 cycles -> ready=1, busy=0, di=0, stb=0, resp_valid=0, resp_out=0 while rst high and the cycle after.
- DIN_N=DOUT_N=8, identity-ROI harness model with din initialized to 0; start with vec_in=8'hA5 ->
  - di = 1,0,1,0,0,1,0,1 in cycles 1..8 after accept;
  - stb=1 only in cycle 9;
  - resp_valid in cycle 18 with resp_out=8'h00.
- Immediate second transaction vec_in=8'h3C, start high in the resp_valid cycle -> accepted with no gap; resp_out=8'hA5 after 18 cycles. A third transaction with 8'hFF returns 8'h3C.
- Pulse start repeatedly during SHIFT and CAPTURE with changing vec_in -> exactly one stb per transaction, resp unchanged, di pattern matches the originally latched vector.
- Assert rst at cycle 5 of SHIFT of vec 8'h5A ->
  - stb never asserted, di=0, ready=1 next cycle;
  - a following transaction with 8'h01 returns the pre-reset harness din contents (8'h3C from the prior test).
- Default DIN_N=DOUT_N=256 with an inverting ROI model; vectors all-zeros then alternating 0xAA.. ->
  - second response = all-ones;
  - resp_valid exactly 514 cycles after accept;
  - bit-exact MSB-first ordering checked on bits 255, 128, 0.
